mem_dump: RTL and testbench

Memory dump engine for the simulation/FPGA top. After a run, it reads a contiguous range of 32-bit data-memory words and streams them out as a byte stream toward the UART transmitter. It is the read-back counterpart of the program loader: the loader writes instruction and data memory from the serial port, and this block reads data memory back out to it. It sits beside the data-memory port mux and takes the memory port only while it is busy.

---
 rtl/mem_dump.sv | 136 +++++++++++++
 tb/tb_mem_dump.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump.sv
// Memory dump engine: reads a contiguous range of 32-bit data words and streams them out LSB-first.
// Optional trailer byte (XOR of all data bytes) is enabled by defining MEM_DUMP_CSUM_EN.
module mem_dump #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    output logic             mem_re,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        SEND,
`ifdef MEM_DUMP_CSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

    state_t           state_q, state_d;
    state_t           after_data;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      shift_q;
    logic [1:0]       byte_idx;
    logic             hs;
`ifdef MEM_DUMP_CSUM_EN
    logic [7:0]       csum_q;
`endif

    assign hs = tx_valid && tx_ready;

    always_comb begin
`ifdef MEM_DUMP_CSUM_EN
        after_data = CSUM;
`else
        after_data = FIN;
`endif
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (num_words == '0) ? after_data : RD;
            RD:   state_d = CAP;
            CAP:  state_d = SEND;
            SEND: if (hs && byte_idx == 2'd3) state_d = (remaining == CNT_W'(1)) ? after_data : RD;
`ifdef MEM_DUMP_CSUM_EN
            CSUM: if (hs) state_d = FIN;
`endif
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            addr_q    <= '0;
            remaining <= '0;
            shift_q   <= '0;
            byte_idx  <= '0;
`ifdef MEM_DUMP_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    addr_q    <= {base_addr[31:2], 2'b00};
                    remaining <= num_words;
`ifdef MEM_DUMP_CSUM_EN
                    csum_q    <= '0;
`endif
                end
                CAP: begin
                    shift_q  <= mem_rdata;
                    byte_idx <= '0;
                end
                SEND: if (hs) begin
                    shift_q  <= shift_q >> 8;
                    byte_idx <= byte_idx + 2'd1;
`ifdef MEM_DUMP_CSUM_EN
                    csum_q   <= csum_q ^ shift_q[7:0];
`endif
                    if (byte_idx == 2'd3) begin
                        // Word finished: the address wraps modulo 2^32 without complaint.
                        remaining <= remaining - CNT_W'(1);
                        addr_q    <= addr_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_re   = (state_q == RD);
        mem_addr = addr_q;
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (state_q == SEND) begin
            tx_valid = 1'b1;
            tx_data  = shift_q[7:0];
        end
`ifdef MEM_DUMP_CSUM_EN
        if (state_q == CSUM) begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
        end
`endif
    end

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: table-driven dumps, hand-written reset/back-to-back sequences,
// and randomized dumps checked against a byte-stream model of the memory contents.
module tb_mem_dump;

`ifdef MEM_DUMP_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_x = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    mem_dump #(.CNT_W(16)) dut (
        .clk(clk), .reset_x(reset_x), .start(start), .base_addr(base_addr),
        .num_words(num_words), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c0 = 0;
    int ready_mode = 0;

    logic [31:0] mem [logic [31:0]];
    logic [7:0]  got_bytes[$];
    logic [31:0] got_addrs[$];
    int          done_cyc[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3E1};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: data valid the cycle after the read strobe.
    always @(posedge clk) mem_rdata <= mem_re ? mem_at(mem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((cyc - c0) % 2) == 1;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!reset_x) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 64'(tx_valid), 64'd1);
                check("tx_hold_data", 64'(tx_data), 64'(prev_data));
            end
            if (tx_valid && tx_ready) got_bytes.push_back(tx_data);
            if (mem_re) got_addrs.push_back(mem_addr);
            if (done) done_cyc.push_back(cyc - c0);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic issue_start(input logic [31:0] b, input int n);
        @(posedge clk); #1;
        got_bytes.delete(); got_addrs.delete(); done_cyc.delete();
        start = 1'b1; base_addr = b; num_words = 16'(n); c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_seen", 64'(done_cyc.size()), 64'd1);
    endtask

    // Reference: the dump is the sequence of words at base, base+4, ... sent LSB first,
    // optionally followed by the XOR of every data byte.
    task automatic check_stream(input logic [31:0] b, input int n);
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  exp_b[$];
        logic [7:0]  x = 8'h00;
        a = {b[31:2], 2'b00};
        check("read_count", 64'(got_addrs.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_addrs.size()) check("read_addr", 64'(got_addrs[i]), 64'(a));
            w = mem_at(a);
            for (int j = 0; j < 4; j++) begin
                exp_b.push_back(8'(w >> (8 * j)));
                x ^= 8'(w >> (8 * j));
            end
            a = a + 32'd4;
        end
        if (CS == 1) exp_b.push_back(x);
        check("byte_count", 64'(got_bytes.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_bytes.size(); i++)
            check("byte", 64'(got_bytes[i]), 64'(exp_b[i]));
    endtask

    task automatic run_dump(input logic [31:0] b, input int n, input int exp_done);
        issue_start(b, n);
        @(negedge clk);
        check("busy_cycle1", 64'(busy), 64'd1);
        check("mem_re_cycle1", 64'(mem_re), 64'(n != 0));
        wait_done(40 * n + 20);
        if (exp_done >= 0 && done_cyc.size() > 0) check("done_cycle", 64'(done_cyc[0]), 64'(exp_done));
        check_stream(b, n);
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        int          mode;
        int          exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'h0000_0100, 1, 0, 6 * 1 + 1 + CS};
        vecs[1] = '{32'h0000_0203, 3, 1, -1};
        vecs[2] = '{32'h0000_0000, 0, 0, 1 + CS};
        vecs[3] = '{32'hFFFF_FFFC, 2, 0, 6 * 2 + 1 + CS};
        mem[32'h0000_0100] = 32'h1122_3344;

        #22;
        check("rst_mem_re", 64'(mem_re), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset_x = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ready_mode = vecs[i].mode;
            run_dump(vecs[i].base, vecs[i].n, vecs[i].exp_done);
        end

        // Extra start mid-dump is ignored; async reset mid-SEND clears all outputs at once.
        ready_mode = 0;
        issue_start(32'h0000_0300, 4);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0000_0900; num_words = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_x = 1'b0;
        #1;
        check("midrst_mem_re", 64'(mem_re), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check("midrst_tx_data", 64'(tx_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_reads", 64'(got_addrs.size()), 64'd1);
        if (got_addrs.size() > 0) check("midrst_addr0", 64'(got_addrs[0]), 64'h300);
        check("midrst_bytes", 64'(got_bytes.size()), 64'd1);
        if (got_bytes.size() > 0) check("midrst_byte0", 64'(got_bytes[0]), 64'(8'(mem_at(32'h300))));
        @(posedge clk); #1;
        reset_x = 1'b1;
        run_dump(32'h0000_0500, 1, 6 + 1 + CS);

        // Back-to-back: second start the cycle after done.
        run_dump(32'h0000_1000, 2, 6 * 2 + 1 + CS);
        run_dump(32'h0000_2000, 1, 6 + 1 + CS);

        ready_mode = 2;
        for (int r = 0; r < 6; r++)
            run_dump($urandom, int'($urandom_range(1, 5)), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
